// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the shared-AES-core scheduler.
// Holds the FSM state encoding, the AES block width and the default watchdog limit.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int AES_CORE_LAT = 12;
    localparam int AES_BLK_W    = 128;
    localparam int TIMEOUT_DEF  = 31;

endpackage

// File: rtl/aes_core_sched_if.sv
// Request fan-in and shared response channel between requesters and the AES scheduler.
// master = requester/bench side, slave = scheduler side.
interface aes_core_sched_if
    import aes_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ*AES_BLK_W-1:0] req_key;
    logic [NREQ*AES_BLK_W-1:0] req_text;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [AES_BLK_W-1:0]      rsp_data;
    logic [IDW-1:0]            rsp_id;
    logic                      rsp_err;

    modport master (
        output req_valid, req_key, req_text, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_key, req_text, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin grant: first asserted req at or above ptr, wrapping mod NREQ.
// Zero latency; no backpressure (pure function of req and ptr).
module aes_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [IDW:0] cand;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            // one extra bit keeps ptr+k from overflowing before the wrap
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (!any && req[cand[IDW-1:0]]) begin
                any                         = 1'b1;
                gnt_idx                     = cand[IDW-1:0];
                gnt_onehot[cand[IDW-1:0]]   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/aes_core_sched.sv
// Shares one AES core among NREQ requesters: round-robin accept, ld/done sequencing, watchdog abort.
// Accept at T -> rsp_valid at T+14; one request in flight; response held until rsp_ready.
module aes_core_sched
    import aes_ctrl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_core_sched_if.slave      bus,
    output logic                 busy,
    output logic                 aes_ld,
    output logic [AES_BLK_W-1:0] aes_key,
    output logic [AES_BLK_W-1:0] aes_text_in,
    input  logic                 aes_done,
    input  logic [AES_BLK_W-1:0] aes_text_out
);
    localparam int             WDW      = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WDOG_MAX = WDW'(TIMEOUT);
    localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NREQ);

    state_t               state, state_nxt;
    logic [IDW-1:0]       rr_ptr, ptr_nxt, gnt_idx;
    logic [NREQ-1:0]      gnt_onehot;
    logic                 any;
    logic [IDW:0]         ptr_sum;
    logic [WDW-1:0]       wdog;
    logic [AES_BLK_W-1:0] key_sel, text_sel;
    logic                 accept, fin_ok, fin_err, rsp_hs;
    logic                 rsp_valid_q, rsp_err_q;
    logic [AES_BLK_W-1:0] rsp_data_q;
    logic [IDW-1:0]       rsp_id_q;

    aes_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req        (bus.req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    // ready is gated by rst so it reads zero while reset is held, even with valid requests
    assign bus.req_ready = (state == IDLE && rst) ? gnt_onehot : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;
    assign aes_ld        = (state == LOAD);
    assign busy          = (state != IDLE);

    always_comb begin
        key_sel  = '0;
        text_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_onehot[i]) begin
                key_sel  = bus.req_key[i*AES_BLK_W +: AES_BLK_W];
                text_sel = bus.req_text[i*AES_BLK_W +: AES_BLK_W];
            end
        end
        ptr_sum = {1'b0, gnt_idx} + 1'b1;
        ptr_nxt = (ptr_sum >= NREQ_W) ? '0 : ptr_sum[IDW-1:0];
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fin_ok    = 1'b0;
        fin_err   = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            IDLE: if (any) begin
                accept    = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: state_nxt = RUN;
            RUN: begin
                // done takes priority over a watchdog expiry in the same cycle
                if (aes_done) begin
                    fin_ok    = 1'b1;
                    state_nxt = RESP;
                end else if (wdog == WDOG_MAX) begin
                    fin_err   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: if (bus.rsp_ready) begin
                rsp_hs    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr      <= '0;
            aes_key     <= '0;
            aes_text_in <= '0;
            wdog        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                aes_key     <= key_sel;
                aes_text_in <= text_sel;
                rsp_id_q    <= gnt_idx;
                rr_ptr      <= ptr_nxt;
            end
            if (state == LOAD)     wdog <= '0;
            else if (state == RUN) wdog <= wdog + 1'b1;
            if (fin_ok) begin
                rsp_data_q  <= aes_text_out;
                rsp_err_q   <= 1'b0;
                rsp_valid_q <= 1'b1;
            end else if (fin_err) begin
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b1;
                rsp_valid_q <= 1'b1;
            end else if (rsp_hs) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_aes_core_sched.sv
// Directed bench for aes_core_sched with a behavioural AES core stand-in.
// Stand-in returns the FIPS-197 ciphertext for the FIPS vector, key^text otherwise.
module tb_aes_core_sched;
    import aes_ctrl_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TMO  = 31;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes_core_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
    logic         busy, aes_ld;
    logic [127:0] aes_key, aes_text_in;
    logic         aes_done     = 1'b0;
    logic [127:0] aes_text_out = '0;

    aes_core_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .aes_ld       (aes_ld),
        .aes_key      (aes_key),
        .aes_text_in  (aes_text_in),
        .aes_done     (aes_done),
        .aes_text_out (aes_text_out)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] model_ct(logic [127:0] k, logic [127:0] t);
        if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        return k ^ t;
    endfunction
    function automatic logic [127:0] key_of(int i);
        return {16{8'(8'h10 + i)}};
    endfunction
    function automatic logic [127:0] text_of(int i);
        return {16{8'(8'ha0 + i)}};
    endfunction

    // core stand-in: done in the cycle lat after aes_ld; lat == 0 means never
    int           lat        = AES_CORE_LAT;
    int           rem        = -1;
    bit           force_done = 1'b0;
    logic [127:0] cap_k, cap_t;
    always @(negedge clk) begin
        aes_done     = 1'b0;
        aes_text_out = '0;
        if (!rst) rem = -1;
        else if (aes_ld) begin
            rem   = lat;
            cap_k = aes_key;
            cap_t = aes_text_in;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                aes_done     = 1'b1;
                aes_text_out = model_ct(cap_k, cap_t);
                rem          = -1;
            end
        end
        if (force_done) begin
            aes_done     = 1'b1;
            aes_text_out = {4{32'hdeadbeef}};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_all_keys;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_key[i*128 +: 128]  = key_of(i);
            bus.req_text[i*128 +: 128] = text_of(i);
        end
    endtask

    task automatic test_reset;
        rst           = 1'b0;
        bus.req_valid = '1;
        repeat (2) tick;
        n_vec++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b expected 0000", bus.req_ready); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
        n_vec++; if (bus.rsp_data !== 128'h0 || bus.rsp_id !== 2'd0 || bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_rsp: got data %h id %0d err %b expected zeros", bus.rsp_data, bus.rsp_id, bus.rsp_err); end
        n_vec++; if (aes_ld !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_ld_busy: got ld %b busy %b expected 0 0", aes_ld, busy); end
        n_vec++; if (aes_key !== 128'h0 || aes_text_in !== 128'h0) begin n_bad++; $display("FAIL rst_core_in: got key %h text %h expected zeros", aes_key, aes_text_in); end
        bus.req_valid = '0;
        rst           = 1'b1;
        tick;
    endtask

    task automatic test_fips;
        int t0;
        bus.req_key  = '0;
        bus.req_text = '0;
        bus.req_key[2*128 +: 128]  = FIPS_KEY;
        bus.req_text[2*128 +: 128] = FIPS_PT;
        bus.req_valid = 4'b0100;
        #1;
        t0 = cyc;
        n_vec++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL fips_ready: got %b expected 0100", bus.req_ready); end
        tick;
        bus.req_valid = '0;
        n_vec++; if (aes_ld !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL fips_ld: got ld %b busy %b expected 1 1", aes_ld, busy); end
        n_vec++; if (aes_key !== FIPS_KEY || aes_text_in !== FIPS_PT) begin n_bad++; $display("FAIL fips_core_in: got key %h text %h", aes_key, aes_text_in); end
        for (int k = 0; k < 40 && !bus.rsp_valid; k++) tick;
        n_vec++; if (cyc - t0 !== 14) begin n_bad++; $display("FAIL fips_latency: got %0d expected 14", cyc - t0); end
        n_vec++; if (bus.rsp_data !== FIPS_CT) begin n_bad++; $display("FAIL fips_data: got %h expected %h", bus.rsp_data, FIPS_CT); end
        n_vec++; if (bus.rsp_id !== 2'd2 || bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL fips_id_err: got id %0d err %b expected 2 0", bus.rsp_id, bus.rsp_err); end
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        n_vec++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL fips_release: got valid %b busy %b expected 0 0", bus.rsp_valid, busy); end
    endtask

    task automatic test_round_robin;
        int exp_id [5] = '{0, 1, 2, 3, 0};
        rst = 1'b0;
        tick;
        rst = 1'b1;
        load_all_keys();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            for (int k = 0; k < 40 && bus.req_ready == 4'b0; k++) tick;
            n_vec++; if (bus.req_ready !== 4'(1 << exp_id[g]) || busy !== 1'b0) begin n_bad++; $display("FAIL rr_grant%0d: got ready %b busy %b expected %b 0", g, bus.req_ready, busy, 4'(1 << exp_id[g])); end
            tick;
            n_vec++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL rr_width%0d: got %b expected 0000", g, bus.req_ready); end
            for (int k = 0; k < 40 && !bus.rsp_valid; k++) tick;
            n_vec++; if (bus.rsp_id !== 2'(exp_id[g]) || bus.rsp_data !== (key_of(exp_id[g]) ^ text_of(exp_id[g]))) begin n_bad++; $display("FAIL rr_rsp%0d: got id %0d data %h expected id %0d", g, bus.rsp_id, bus.rsp_data, exp_id[g]); end
            tick;
            if (g == 4) bus.req_valid = '0;
        end
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int bad = 0;
        logic [127:0] exp_d;
        exp_d = key_of(1) ^ text_of(1);
        bus.req_valid = 4'b1010;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_grant: got %b expected 0010", bus.req_ready); end
        tick;
        bus.req_valid = 4'b1000;
        for (int k = 0; k < 40 && !bus.rsp_valid; k++) tick;
        n_vec++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_rsp_valid: got %b expected 1", bus.rsp_valid); end
        for (int k = 0; k < 20; k++) begin
            tick;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.rsp_id !== 2'd1 ||
                bus.rsp_err !== 1'b0 || bus.req_ready !== 4'b0 || busy !== 1'b1) bad++;
        end
        n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b expected 0", bus.rsp_valid); end
    endtask

    // lat_sel 0: core never completes; otherwise done lands in the cycle wdog == TMO
    task automatic test_watchdog(input int lat_sel, input int req, input logic exp_err);
        int tl;
        logic [127:0] exp_d;
        exp_d = exp_err ? 128'h0 : (key_of(req) ^ text_of(req));
        lat = lat_sel;
        bus.req_valid = 4'(1 << req);
        #1;
        n_vec++; if (bus.req_ready !== 4'(1 << req)) begin n_bad++; $display("FAIL wd_grant%0d: got %b expected %b", req, bus.req_ready, 4'(1 << req)); end
        tick;
        bus.req_valid = '0;
        tl = cyc;
        for (int k = 0; k < 60 && !bus.rsp_valid; k++) tick;
        // wdog reaches TMO in cycle LOAD+TMO+1; the registered response shows one cycle later
        n_vec++; if (bus.rsp_valid !== 1'b1 || cyc - tl !== TMO + 2) begin n_bad++; $display("FAIL wd_timing%0d: got valid %b at +%0d expected 1 at +%0d", req, bus.rsp_valid, cyc - tl, TMO + 2); end
        n_vec++; if (bus.rsp_err !== exp_err || bus.rsp_data !== exp_d || bus.rsp_id !== 2'(req)) begin n_bad++; $display("FAIL wd_rsp%0d: got err %b data %h id %0d expected err %b data %h", req, bus.rsp_err, bus.rsp_data, bus.rsp_id, exp_err, exp_d); end
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        lat = AES_CORE_LAT;
    endtask

    task automatic test_spurious_done;
        int bad = 0;
        force_done = 1'b1;
        tick;
        tick;
        force_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
            tick;
        end
        n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL spurious_done: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid_run;
        int t0;
        bus.req_valid = 4'b0010;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL mr_grant: got %b expected 0010", bus.req_ready); end
        tick;
        bus.req_valid = '0;
        repeat (5) tick;
        bus.req_valid = 4'b1010;
        rst = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || aes_ld !== 1'b0 || bus.req_ready !== 4'b0 || bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mr_ctl: got busy %b ld %b ready %b valid %b expected zeros", busy, aes_ld, bus.req_ready, bus.rsp_valid); end
        n_vec++; if (aes_key !== 128'h0 || aes_text_in !== 128'h0 || bus.rsp_id !== 2'd0) begin n_bad++; $display("FAIL mr_regs: got key %h text %h id %0d expected zeros", aes_key, aes_text_in, bus.rsp_id); end
        tick;
        rst = 1'b1;
        #1;
        t0 = cyc;
        // pointer back at 0 picks requester 1; a stale pointer of 2 would pick 3
        n_vec++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL mr_ptr: got %b expected 0010", bus.req_ready); end
        tick;
        bus.req_valid = '0;
        for (int k = 0; k < 40 && !bus.rsp_valid; k++) tick;
        n_vec++; if (bus.rsp_valid !== 1'b1 || cyc - t0 !== 14) begin n_bad++; $display("FAIL mr_latency: got valid %b at +%0d expected 1 at +14", bus.rsp_valid, cyc - t0); end
        n_vec++; if (bus.rsp_data !== (key_of(1) ^ text_of(1)) || bus.rsp_id !== 2'd1 || bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL mr_rsp: got data %h id %0d err %b", bus.rsp_data, bus.rsp_id, bus.rsp_err); end
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_key   = '0;
        bus.req_text  = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_fips();
        test_round_robin();
        test_backpressure();
        test_watchdog(0, 0, 1'b1);
        test_watchdog(TMO + 1, 2, 1'b0);
        test_spurious_done();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/aes_core_sched.md
Name: aes_core_sched

Overview:
Shares one aes_cipher core between NREQ independent requesters. Each requester presents a (key, plaintext) request on a valid/ready channel. The block picks one round-robin, sequences the core's ld/done protocol and returns the ciphertext, tagged with the requester id, on a single shared response channel. A watchdog guards against a core that never asserts done.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ
TIMEOUT, 31, RUN-state cycles without aes_done before the request is aborted with an error (must be > 12)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester request accept (one-hot or zero)
req_key  in  NREQ*128  per-requester key; slice i = [i*128 +: 128]
req_text  in  NREQ*128  per-requester plaintext, same slicing
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_data  out  128  ciphertext (zero on error)
rsp_id  out  IDW  index of the requester that owns the response
rsp_err  out  1  watchdog abort flag, qualified by rsp_valid
busy  out  1  high in every state except IDLE
aes_ld  out  1  one-cycle load strobe to the core
aes_key  out  128  key to the core
aes_text_in  out  128  plaintext to the core
aes_done  in  1  core done pulse
aes_text_out  in  128  core ciphertext; valid in the aes_done cycle

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-low.
- Reset values:
  - FSM in IDLE; rr_ptr = 0.
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0.
  - aes_ld = 0, aes_key = 0, aes_text_in = 0, busy = 0, wdog = 0.
- FSM states: IDLE -> LOAD -> RUN -> RESP -> IDLE.
- IDLE:
  - grant = first i with req_valid[i], searching from rr_ptr upward and wrapping mod NREQ.
  - req_ready[grant] is asserted combinationally in IDLE only; every other bit is 0.
  - On handshake: register key/text into aes_key/aes_text_in and grant into rsp_id; rr_ptr <= (grant+1) mod NREQ; go to LOAD.
  - No req_valid: stay in IDLE; rr_ptr unchanged.
- LOAD:
  - aes_ld = 1 for exactly this cycle; wdog <= 0; go to RUN.
  - aes_key/aes_text_in stay stable from LOAD until the next IDLE accept.
- RUN: wdog increments every cycle.
  - aes_done = 1: rsp_data <= aes_text_out, rsp_err <= 0, rsp_valid <= 1; go to RESP.
  - Else, if wdog == TIMEOUT: rsp_data <= 0, rsp_err <= 1, rsp_valid <= 1; go to RESP.
  - aes_done in the same cycle as wdog == TIMEOUT: done wins, no error.
- RESP:
  - rsp_valid, rsp_data, rsp_id and rsp_err are held stable until rsp_ready.
  - On handshake: rsp_valid <= 0; go to IDLE.
  - Backpressure of any length is legal.
- Latency:
  - Core done arrives 12 cycles after the aes_ld cycle.
  - Accept at cycle T -> aes_ld at T+1 -> aes_done at T+13 -> rsp_valid at T+14.
  - Next accept no earlier than the cycle after the response handshake.
- aes_done outside RUN: ignored; no state change.
- Requester dropping req_valid before grant: legal; no grant is issued to it.
- Async reset mid-operation: immediate return to reset values. Any in-flight core result is discarded; the next LOAD re-launches the core.
- No request queuing: at most one request in flight.

Decomposition:
- Package aes_ctrl_pkg:
  - state enum {IDLE, LOAD, RUN, RESP} (2 bits).
  - AES_CORE_LAT = 12, AES_BLK_W = 128, default TIMEOUT.
- Sub-module aes_rr_arbiter:
  - Combinational round-robin grant: inputs req[NREQ] and ptr[IDW]; outputs gnt_onehot[NREQ], gnt_idx[IDW], any.
  - Pointer register kept in the parent.

Test Plan:
- Single request, FIPS-197 vector: requester 2, key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, core model attached.
  -> rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id = 2, rsp_err = 0, rsp_valid 14 cycles after accept.
- All 4 requesters valid continuously from reset -> grant order 0,1,2,3,0; each req_ready one-hot, one cycle wide, only in IDLE.
- rsp_ready held low for 20 cycles after rsp_valid -> rsp_data/rsp_id/rsp_err stable; no new req_ready; busy = 1 throughout.
- Core model never asserts done -> rsp_valid with rsp_err = 1 and rsp_data = 0, at cycle TIMEOUT+1 after the LOAD cycle (wdog = TIMEOUT).
- Core model asserts aes_done in the exact cycle wdog == TIMEOUT -> rsp_err = 0 and rsp_data = core output. Separately, spurious aes_done while IDLE -> no response generated.
- rst driven low during RUN (cycle T+6) -> all outputs at reset values immediately. After release, re-issued request completes correctly; rr_ptr restarts at 0.
